sfilt_mc: RTL and testbench

//   Multi-channel, parametrised successor of the single-channel command-driven MAC filter.

---
 rtl/sfilt_mc_if.sv | 27 ++
 rtl/sfilt_mc.sv | 192 +++++++++++++++++++
 tb/tb_sfilt_mc.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/sfilt_mc_if.sv
// sfilt_mc bus bundle: command push side and result pop side.
// The master drives commands and stopin. The slave drives results and flow status.
interface sfilt_mc_if #(
  parameter int DW  = 32,
  parameter int CHW = 2
);
  logic           pushin;
  logic [2:0]     cmd;
  logic [CHW-1:0] ch;
  logic [DW-1:0]  q;
  logic [DW-1:0]  h;
  logic           stopout;
  logic           pushout;
  logic           stopin;
  logic [DW-1:0]  z;
  logic           err;

  modport master (
    output pushin, cmd, ch, q, h, stopin,
    input  stopout, pushout, z, err
  );

  modport slave (
    input  pushin, cmd, ch, q, h, stopin,
    output stopout, pushout, z, err
  );
endinterface

// File: rtl/sfilt_mc.sv
// Multi-channel command-driven MAC filter.
// Pipelined multiply, per-channel accumulators, and a credit-guarded output FIFO.
module sfilt_mc #(
  parameter int DW        = 32,
  parameter int AW        = 64,
  parameter int NCH       = 4,
  parameter int MULT_LAT  = 3,
  parameter int OUT_DEPTH = 4
) (
  input logic      clk,
  input logic      rst,
  sfilt_mc_if.slave sif
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW  = $clog2(OUT_DEPTH + 1);

  localparam logic [2:0] C_LOAD   = 3'd0;
  localparam logic [2:0] C_MAC    = 3'd1;
  localparam logic [2:0] C_SHR    = 3'd2;
  localparam logic [2:0] C_OUT    = 3'd3;
  localparam logic [2:0] C_OUTSAT = 3'd4;
  localparam logic [2:0] C_CLR    = 3'd5;

  localparam logic signed [AW-1:0] SMAX =
    {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN =
    {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] ZMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] ZMIN = {1'b1, {(DW-1){1'b0}}};

  typedef struct packed {
    logic           v;
    logic           ok;
    logic [2:0]     cmd;
    logic [CHW-1:0] ch;
    logic [DW-1:0]  q;
    logic [DW-1:0]  h;
  } stg_t;

  stg_t                  stg_q [MULT_LAT];
  stg_t                  stg_d [MULT_LAT];
  logic signed [AW-1:0]  acc_q [NCH];
  logic signed [AW-1:0]  acc_d [NCH];
  logic [DW-1:0]         mem_q [OUT_DEPTH];
  logic [DW-1:0]         mem_d [OUT_DEPTH];
  logic [PW-1:0]         wp_q, wp_d, rp_q, rp_d, rp_nx;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DW-1:0]         z_q, z_d;
  logic                  err_q, err_d;

  logic [31:0]           occ;
  logic                  stopout, push_ok, ch_ok;
  logic                  ex_go, wr, pop;
  logic [DW-1:0]         wdata;
  stg_t                  ex;

  logic signed [2*DW-1:0] prod;
  logic signed [AW-1:0]   prod_x, acc_c, asr, shr_res;
  logic [AW-1:0]          rmask;
  logic [31:0]            s32;
  logic                   rbit;
  logic [DW-1:0]          sat_res;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credits count both queued results and anything still in the pipe.
  always_comb begin
    occ = 32'(cnt_q);
    for (int i = 0; i < MULT_LAT; i++) begin
      occ = occ + 32'(stg_q[i].v);
    end
  end

  assign stopout = occ >= 32'(OUT_DEPTH);
  assign push_ok = sif.pushin && !stopout;
  assign ch_ok   = 32'(sif.ch) < 32'(NCH);

  always_comb begin
    stg_d[0]     = '0;
    stg_d[0].v   = push_ok;
    stg_d[0].ok  = ch_ok;
    stg_d[0].cmd = sif.cmd;
    stg_d[0].ch  = sif.ch;
    stg_d[0].q   = sif.q;
    stg_d[0].h   = sif.h;
    for (int i = 1; i < MULT_LAT; i++) begin
      stg_d[i] = stg_q[i-1];
    end
  end

  assign ex     = stg_q[MULT_LAT-1];
  assign ex_go  = ex.v && ex.ok;
  assign prod   = $signed(ex.q) * $signed(ex.h);
  assign prod_x = AW'(prod);
  assign acc_c  = acc_q[ex.ch];

  // Round half up: add back the last bit shifted out.
  assign s32     = {25'd0, ex.h[6:0]};
  assign asr     = acc_c >>> s32;
  assign rmask   = {{(AW-1){1'b0}}, 1'b1} << (s32 - 32'd1);
  assign rbit    = |(acc_c & rmask);
  assign shr_res = (s32 == 32'd0)       ? acc_c :
                   (s32 >= 32'(AW))     ? '0    :
                   asr + {{(AW-1){1'b0}}, rbit};

  assign sat_res = (acc_c > SMAX) ? ZMAX :
                   (acc_c < SMIN) ? ZMIN :
                   acc_c[DW-1:0];

  always_comb begin
    acc_d = acc_q;
    wr    = 1'b0;
    wdata = '0;
    if (ex_go) begin
      unique case (ex.cmd)
        C_LOAD:   acc_d[ex.ch] = prod_x;
        C_MAC:    acc_d[ex.ch] = acc_c + prod_x;
        C_SHR:    acc_d[ex.ch] = shr_res;
        C_OUT: begin
          wr           = 1'b1;
          wdata        = acc_c[DW-1:0];
          acc_d[ex.ch] = '0;
        end
        C_OUTSAT: begin
          wr           = 1'b1;
          wdata        = sat_res;
          acc_d[ex.ch] = '0;
        end
        C_CLR:    acc_d[ex.ch] = '0;
        default:  acc_d[ex.ch] = acc_c;
      endcase
    end
  end

  assign pop   = (cnt_q != '0) && !sif.stopin;
  assign rp_nx = inc(rp_q);

  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = pop ? rp_nx : rp_q;
    cnt_d = cnt_q + CW'(wr) - CW'(pop);
    if (wr) begin
      mem_d[wp_q] = wdata;
      wp_d        = inc(wp_q);
    end
  end

  // z is a register so it keeps the last head once the queue drains.
  always_comb begin
    z_d = z_q;
    if (cnt_d != '0) begin
      if (wr && (cnt_q == '0 || (pop && cnt_q == CW'(1)))) begin
        z_d = wdata;
      end else if (pop) begin
        z_d = mem_q[rp_nx];
      end
    end
  end

  assign err_d = err_q | (sif.pushin && (stopout || !ch_ok));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MULT_LAT; i++) stg_q[i] <= '0;
      for (int i = 0; i < NCH; i++) acc_q[i] <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) mem_q[i] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      z_q   <= '0;
      err_q <= 1'b0;
    end else begin
      stg_q <= stg_d;
      acc_q <= acc_d;
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      z_q   <= z_d;
      err_q <= err_d;
    end
  end

  assign sif.stopout = stopout;
  assign sif.pushout = cnt_q != '0;
  assign sif.z       = z_q;
  assign sif.err     = err_q;
endmodule

// File: tb/tb_sfilt_mc.sv
// Directed bench for sfilt_mc.
// Hand-computed results are checked against a monitored output queue.
module tb_sfilt_mc;
  localparam int DW  = 32;
  localparam int NCH = 4;
  localparam int CHW = 2;
  localparam int ML  = 3;
  localparam int OD  = 4;

  localparam logic [2:0] LOAD   = 3'd0;
  localparam logic [2:0] MAC    = 3'd1;
  localparam logic [2:0] SHR    = 3'd2;
  localparam logic [2:0] OUT    = 3'd3;
  localparam logic [2:0] OUTSAT = 3'd4;
  localparam logic [2:0] CLR    = 3'd5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;
  logic [DW-1:0] outq [$];

  sfilt_mc_if #(.DW(DW), .CHW(CHW)) sif ();

  sfilt_mc #(
    .DW(DW), .AW(64), .NCH(NCH),
    .MULT_LAT(ML), .OUT_DEPTH(OD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sif(sif.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && sif.pushout && !sif.stopin) outq.push_back(sif.z);
  end

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drv(logic [2:0] c, logic [CHW-1:0] k,
                     logic [DW-1:0] qv, logic [DW-1:0] hv,
                     bit honor = 1'b1);
    int w = 0;
    if (honor) begin
      while (sif.stopout && w < 50) begin
        @(posedge clk); #1;
        w++;
      end
      if (w == 50) chk("stall_timeout", 64'(sif.stopout), 64'd0);
    end
    sif.pushin = 1'b1;
    sif.cmd    = c;
    sif.ch     = k;
    sif.q      = qv;
    sif.h      = hv;
    @(posedge clk); #1;
    sif.pushin = 1'b0;
  endtask

  task automatic expect_out(string tag, logic [DW-1:0] exp);
    int w = 0;
    while (outq.size() == 0 && w < 60) begin
      @(negedge clk); #1;
      w++;
    end
    if (outq.size() == 0) begin
      chk({tag, "_timeout"}, 64'(outq.size()), 64'd1);
    end else begin
      chk(tag, 64'(outq.pop_front()), 64'(exp));
    end
  endtask

  logic signed [DW-1:0] t3_q [7] = '{11, -11, 10, 5, 5, -5, -1};
  logic [DW-1:0]        t3_s [7] = '{2, 2, 2, 0, 100, 100, 1};
  logic [DW-1:0]        t3_e [7] = '{32'd3, 32'hFFFF_FFFD, 32'd3, 32'd5,
                                     32'd0, 32'd0, 32'd0};

  logic [DW-1:0] t4_q [7] = '{32'h0010_0000, 32'hFFF0_0000, 32'h0010_0000,
                              32'h4000_0000, 32'h4000_0000, 32'hC000_0000,
                              32'hFFFF_FFF9};
  logic [DW-1:0] t4_h [7] = '{32'h0010_0000, 32'h0010_0000, 32'h0010_0000,
                              32'd2, 32'd2, 32'd2, 32'd1};
  logic [2:0]    t4_c [7] = '{OUTSAT, OUTSAT, OUT, OUTSAT, OUT, OUTSAT, OUTSAT};
  logic [DW-1:0] t4_e [7] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h0,
                              32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000,
                              32'hFFFF_FFF9};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    sif.pushin = 1'b0;
    sif.cmd    = '0;
    sif.ch     = '0;
    sif.q      = '0;
    sif.h      = '0;
    sif.stopin = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_pushout", 64'(sif.pushout), 64'd0);
    chk("rst_z", 64'(sif.z), 64'd0);
    chk("rst_err", 64'(sif.err), 64'd0);
    chk("rst_stopout", 64'(sif.stopout), 64'd0);

    // T1
    drv(LOAD, 0, 3, 4);
    drv(MAC, 0, -2, 5);
    drv(OUT, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("t1_lat_early", 64'(sif.pushout), 64'd0);
    @(negedge clk);
    chk("t1_lat_pushout", 64'(sif.pushout), 64'd1);
    chk("t1_lat_z", 64'(sif.z), 64'd2);
    expect_out("t1_z", 2);
    drv(OUT, 0, 0, 0);
    expect_out("t1_acc0_clr", 0);

    // T2
    drv(LOAD, 1, 7, 7);
    drv(LOAD, 2, 1, 1);
    drv(MAC, 1, 1, 1);
    drv(OUT, 2, 0, 0);
    drv(OUT, 1, 0, 0);
    expect_out("t2_ch2", 1);
    expect_out("t2_ch1", 50);

    // T3
    for (int i = 0; i < 7; i++) begin
      drv(LOAD, 3, t3_q[i], 1);
      drv(SHR, 3, 0, t3_s[i]);
      drv(OUT, 3, 0, 0);
      expect_out($sformatf("t3_shr%0d", i), t3_e[i]);
    end

    // T4
    for (int i = 0; i < 7; i++) begin
      drv(LOAD, 2, t4_q[i], t4_h[i]);
      drv(t4_c[i], 2, 0, 0);
      expect_out($sformatf("t4_sat%0d", i), t4_e[i]);
    end
    drv(LOAD, 2, 9, 1);
    drv(CLR, 2, 0, 0);
    drv(OUT, 2, 0, 0);
    expect_out("t4_clr", 0);

    // T5
    repeat (6) @(posedge clk);
    #1 sif.stopin = 1'b1;
    for (int i = 0; i < 4; i++) drv(LOAD, CHW'(i), 10 + i, 1);
    repeat (6) @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t5_stop%0d", i), 64'(sif.stopout), 64'(i >= 4));
      if (i == 4) chk("t5_err_pre", 64'(sif.err), 64'd0);
      drv(OUT, CHW'(i % 4), 0, 0, 1'b0);
    end
    chk("t5_err", 64'(sif.err), 64'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("t5_full_stop", 64'(sif.stopout), 64'd1);
    chk("t5_full_push", 64'(sif.pushout), 64'd1);
    sif.stopin = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("t5_drain_cnt", 64'(outq.size()), 64'd4);
    @(negedge clk);
    chk("t5_empty", 64'(sif.pushout), 64'd0);
    chk("t5_hold_z", 64'(sif.z), 64'd13);
    for (int i = 0; i < 4; i++) begin
      expect_out($sformatf("t5_ord%0d", i), 10 + i);
    end
    chk("t5_extra", 64'(outq.size()), 64'd0);

    // T6
    sif.stopin = 1'b1;
    drv(LOAD, 0, 5, 1);
    drv(LOAD, 1, 6, 1);
    drv(OUT, 0, 0, 0);
    drv(OUT, 1, 0, 0);
    repeat (6) @(posedge clk);
    #1;
    chk("t6_fifo_busy", 64'(sif.pushout), 64'd1);
    drv(MAC, 0, 1, 1);
    drv(MAC, 0, 1, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sif.stopin = 1'b0;
    @(negedge clk);
    chk("t6_pushout", 64'(sif.pushout), 64'd0);
    chk("t6_z", 64'(sif.z), 64'd0);
    chk("t6_err", 64'(sif.err), 64'd0);
    chk("t6_stopout", 64'(sif.stopout), 64'd0);
    repeat (6) @(negedge clk);
    chk("t6_no_late", 64'(sif.pushout), 64'd0);
    outq.delete();
    drv(OUT, 0, 0, 0);
    expect_out("t6_acc0", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
